// File: rtl/purchase_sequencer.sv
// purchase_sequencer: FIFO-buffered purchase transactions replayed as choose/insert/change/gap strobes
module purchase_sequencer #(
  parameter int N_COINS = 3,
  parameter int COUNT_W = 8,
  parameter logic [N_COINS*8-1:0] COIN_VALUES = {8'd100, 8'd50, 8'd25},
  parameter int MONEY_W = 8,
  parameter int PROD_W = 8,
  parameter int DEPTH = 4,
  parameter int PHASE_CYCLES = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [PROD_W-1:0]          tx_produto,
  input  logic [N_COINS*COUNT_W-1:0] tx_moedas,
  input  logic                       troco_ok,
  output logic                       escolher,
  output logic                       inserir_dinheiro,
  output logic                       dar_troco,
  output logic [PROD_W-1:0]          produto_escolhido,
  output logic [MONEY_W-1:0]         dinheiro_inserido,
  output logic [N_COINS*COUNT_W-1:0] moedas_inseridas,
  output logic                       busy,
  output logic                       soma_sat,
  output logic                       timeout_err,
  output logic [15:0]                done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = N_COINS * COUNT_W;
  localparam int MAXC = PHASE_CYCLES > TIMEOUT ? PHASE_CYCLES : TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;
  localparam int SUM_RAW = COUNT_W + 8 + $clog2(N_COINS) + 1;
  localparam int SUM_W = SUM_RAW > MONEY_W ? SUM_RAW : MONEY_W + 1;
  typedef enum logic [2:0] {IDLE, CHOOSE, INSERT, CHANGE, GAP} state_t;
  state_t state;
  logic [PROD_W-1:0] mem_p [DEPTH];
  logic [MW-1:0] mem_m [DEPTH];
  logic [AW:0] wp, rp;
  logic [CW-1:0] phase;
  logic [MONEY_W-1:0] sum_q;
  logic [MW-1:0] coins_q;
  logic [MW-1:0] head_m;
  logic [SUM_W-1:0] sum_full;
  logic empty, full, push, pop, sat, last_phase;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign tx_ready = reset_n & ~full;
  assign push = tx_valid & tx_ready;
  assign pop = (state == IDLE) & run & ~empty;
  assign busy = state != IDLE;
  assign head_m = mem_m[rp[AW-1:0]];
  assign last_phase = phase == CW'(PHASE_CYCLES - 1);
  assign sat = sum_full > SUM_W'({MONEY_W{1'b1}});
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < N_COINS; i++)
      sum_full = sum_full + SUM_W'(head_m[i*COUNT_W +: COUNT_W]) * SUM_W'(COIN_VALUES[i*8 +: 8]);
  end
  // storage carries no reset; the pointers alone define occupancy
  always_ff @(posedge clock)
    if (push) begin
      mem_p[wp[AW-1:0]] <= tx_produto;
      mem_m[wp[AW-1:0]] <= tx_moedas;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      phase <= '0;
      sum_q <= '0;
      coins_q <= '0;
      escolher <= 1'b0;
      inserir_dinheiro <= 1'b0;
      dar_troco <= 1'b0;
      produto_escolhido <= '0;
      dinheiro_inserido <= '0;
      moedas_inseridas <= '0;
      soma_sat <= 1'b0;
      timeout_err <= 1'b0;
      done_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state <= CHOOSE;
          phase <= '0;
          escolher <= 1'b1;
          produto_escolhido <= mem_p[rp[AW-1:0]];
          sum_q <= sat ? {MONEY_W{1'b1}} : sum_full[MONEY_W-1:0];
          coins_q <= head_m;
          if (sat) soma_sat <= 1'b1;
        end
        CHOOSE: if (last_phase) begin
          state <= INSERT;
          phase <= '0;
          escolher <= 1'b0;
          inserir_dinheiro <= 1'b1;
          dinheiro_inserido <= sum_q;
          moedas_inseridas <= coins_q;
        end else phase <= phase + 1'b1;
        INSERT: if (last_phase) begin
          state <= CHANGE;
          phase <= '0;
          inserir_dinheiro <= 1'b0;
          dar_troco <= 1'b1;
        end else phase <= phase + 1'b1;
        // phase counts CHANGE cycles already spent waiting for troco_ok
        CHANGE: if (troco_ok || phase == CW'(TIMEOUT - 1)) begin
          state <= GAP;
          phase <= '0;
          dar_troco <= 1'b0;
          produto_escolhido <= '0;
          dinheiro_inserido <= '0;
          moedas_inseridas <= '0;
          done_count <= done_count + 1'b1;
          if (!troco_ok) timeout_err <= 1'b1;
        end else phase <= phase + 1'b1;
        GAP: if (last_phase) begin
          state <= IDLE;
          phase <= '0;
        end else phase <= phase + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_purchase_sequencer.sv
// tb_purchase_sequencer: directed scenario tasks against hand-computed strobe/data values
module tb_purchase_sequencer;
  logic clock = 1'b0;
  logic reset_n, run, tx_valid, tx_ready, troco_ok;
  logic [7:0] tx_produto;
  logic [23:0] tx_moedas;
  logic escolher, inserir_dinheiro, dar_troco, busy, soma_sat, timeout_err;
  logic [7:0] produto_escolhido, dinheiro_inserido;
  logic [23:0] moedas_inseridas;
  logic [15:0] done_count;
  logic [43:0] obs;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  assign obs = {escolher, inserir_dinheiro, dar_troco, busy, produto_escolhido, dinheiro_inserido, moedas_inseridas};
  purchase_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_produto(tx_produto), .tx_moedas(tx_moedas), .troco_ok(troco_ok), .escolher(escolher),
    .inserir_dinheiro(inserir_dinheiro), .dar_troco(dar_troco), .produto_escolhido(produto_escolhido),
    .dinheiro_inserido(dinheiro_inserido), .moedas_inseridas(moedas_inseridas), .busy(busy),
    .soma_sat(soma_sat), .timeout_err(timeout_err), .done_count(done_count)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [7:0] p, input logic [23:0] m);
    tx_valid = 1'b1;
    tx_produto = p;
    tx_moedas = m;
    tick();
    tx_valid = 1'b0;
  endtask
  task automatic test_reset;
    reset_n = 1'b0; run = 1'b0; tx_valid = 1'b0; troco_ok = 1'b1;
    tx_produto = '0; tx_moedas = '0;
    #12;
    checks++;
    if ({obs, tx_ready, soma_sat, timeout_err, done_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {obs, tx_ready, soma_sat, timeout_err, done_count});
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({tx_ready, busy, done_count} !== {1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_release got %b/%b/%0d exp 1/0/0", tx_ready, busy, done_count);
    end
  endtask
  task automatic test_single;
    run = 1'b1; troco_ok = 1'b1;
    push(8'd1, 24'h010100);
    tick();
    checks++;
    if (obs !== {4'b1001, 8'd1, 8'd0, 24'h0}) begin
      errors++; $display("FAIL single_choose got %h exp %h", obs, {4'b1001, 8'd1, 8'd0, 24'h0});
    end
    tick();
    checks++;
    if (obs !== {4'b0101, 8'd1, 8'd150, 24'h010100}) begin
      errors++; $display("FAIL single_insert got %h exp %h", obs, {4'b0101, 8'd1, 8'd150, 24'h010100});
    end
    tick();
    checks++;
    if (obs !== {4'b0011, 8'd1, 8'd150, 24'h010100}) begin
      errors++; $display("FAIL single_change got %h exp %h", obs, {4'b0011, 8'd1, 8'd150, 24'h010100});
    end
    tick();
    checks++;
    if ({obs, done_count} !== {4'b0001, 40'h0, 16'd1}) begin
      errors++; $display("FAIL single_gap got %h done %0d exp busy-only done 1", obs, done_count);
    end
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL single_idle got %h exp 0", obs);
    end
  endtask
  task automatic test_back_to_back;
    int gap;
    gap = 0;
    push(8'd1, 24'h010100);
    push(8'd2, 24'h000102);
    checks++;
    if ({escolher, produto_escolhido} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL b2b_first_choose got %b/%0d exp 1/1", escolher, produto_escolhido);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (escolher && produto_escolhido == 8'd2) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap !== 5) begin
      errors++; $display("FAIL b2b_spacing got %0d exp 5", gap);
    end
    tick();
    checks++;
    if (obs !== {4'b0101, 8'd2, 8'd100, 24'h000102}) begin
      errors++; $display("FAIL b2b_second_insert got %h exp %h", obs, {4'b0101, 8'd2, 8'd100, 24'h000102});
    end
    repeat (3) tick();
    checks++;
    if ({busy, done_count} !== {1'b0, 16'd3}) begin
      errors++; $display("FAIL b2b_done got %b/%0d exp 0/3", busy, done_count);
    end
  endtask
  task automatic test_saturation;
    checks++;
    if (soma_sat !== 1'b0) begin
      errors++; $display("FAIL sat_before got %b exp 0", soma_sat);
    end
    push(8'd3, 24'h030000);
    repeat (2) tick();
    checks++;
    if ({inserir_dinheiro, dinheiro_inserido, soma_sat} !== {1'b1, 8'd255, 1'b1}) begin
      errors++; $display("FAIL sat_insert got %b/%0d/%b exp 1/255/1", inserir_dinheiro, dinheiro_inserido, soma_sat);
    end
    repeat (3) tick();
    push(8'd4, 24'h000001);
    repeat (2) tick();
    checks++;
    if ({inserir_dinheiro, dinheiro_inserido, soma_sat} !== {1'b1, 8'd25, 1'b1}) begin
      errors++; $display("FAIL sat_sticky got %b/%0d/%b exp 1/25/1", inserir_dinheiro, dinheiro_inserido, soma_sat);
    end
    repeat (3) tick();
    checks++;
    if ({busy, done_count} !== {1'b0, 16'd5}) begin
      errors++; $display("FAIL sat_done got %b/%0d exp 0/5", busy, done_count);
    end
  endtask
  task automatic test_timeout;
    int n;
    n = 0;
    troco_ok = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_before got %b exp 0", timeout_err);
    end
    push(8'd5, 24'h000004);
    repeat (3) tick();
    while (dar_troco && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL timeout_len got %0d exp 16", n);
    end
    checks++;
    if ({obs, timeout_err, done_count} !== {4'b0001, 40'h0, 1'b1, 16'd6}) begin
      errors++; $display("FAIL timeout_gap got %h err %b done %0d exp busy-only/1/6", obs, timeout_err, done_count);
    end
    troco_ok = 1'b1;
    tick();
  endtask
  task automatic test_fifo_full;
    int k;
    logic rdy_ok;
    k = 0;
    rdy_ok = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (tx_ready !== (i < 4)) rdy_ok = 1'b0;
      push(8'(10 + i), 24'(i + 1));
    end
    checks++;
    if ({rdy_ok, tx_ready, busy} !== 3'b100) begin
      errors++; $display("FAIL full_ready got %b/%b/%b exp 1/0/0", rdy_ok, tx_ready, busy);
    end
    run = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (escolher) begin
        checks++;
        if (produto_escolhido !== 8'(10 + k)) begin
          errors++; $display("FAIL full_order got %0d exp %0d", produto_escolhido, 10 + k);
        end
        k++;
      end
    end
    checks++;
    if ({8'(k), tx_ready, busy, done_count} !== {8'd4, 1'b1, 1'b0, 16'd10}) begin
      errors++; $display("FAIL full_replay got %0d/%b/%b/%0d exp 4/1/0/10", k, tx_ready, busy, done_count);
    end
  endtask
  task automatic test_reset_mid;
    logic quiet;
    quiet = 1'b1;
    push(8'd7, 24'h000002);
    repeat (2) tick();
    checks++;
    if (inserir_dinheiro !== 1'b1) begin
      errors++; $display("FAIL mid_in_insert got %b exp 1", inserir_dinheiro);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs, tx_ready, soma_sat, timeout_err, done_count} !== '0) begin
      errors++; $display("FAIL mid_async got %h exp 0", {obs, tx_ready, soma_sat, timeout_err, done_count});
    end
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (escolher || inserir_dinheiro || dar_troco || busy) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL mid_flushed got activity exp none");
    end
    push(8'd8, 24'h000001);
    tick();
    checks++;
    if ({escolher, produto_escolhido} !== {1'b1, 8'd8}) begin
      errors++; $display("FAIL mid_new_push got %b/%0d exp 1/8", escolher, produto_escolhido);
    end
    repeat (4) tick();
    checks++;
    if (done_count !== 16'd1) begin
      errors++; $display("FAIL mid_done got %0d exp 1", done_count);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_timeout();
    test_fifo_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
